// File: rtl/mul_hilo_seq.sv
// rtl/mul_hilo_seq.sv - shift-add MUL/MAD sequencer owning HI/LO; optional EARLY_TERM_EN stops once the multiplier is exhausted
module mul_hilo_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [1:0]       rd_sel,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [2*WIDTH-1:0]   acc;
  logic [CW-1:0]        cnt;
  logic                 op_q;

  logic [2*WIDTH-1:0]   acc_step;
  logic [2*WIDTH-1:0]   hilo_mad;
  logic                 last_run;
  logic                 rd_hit;

  // One shift-add step: fold in the shifted multiplicand when the current multiplier bit is set
  always_comb begin
    acc_step = acc;
    if (mplier[0]) begin
      acc_step = acc + mcand;
    end
  end

  // MAD accumulates into the committed pair; the carry out of the top bit is dropped
  assign hilo_mad = {hi, lo} + acc;
  assign last_run = (cnt == CNT_LAST);

  // Sequencer: latch operands on start, step WIDTH times (or fewer with early exit), commit HI/LO in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      hi     <= '0;
      lo     <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      op_q   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {{WIDTH{1'b0}}, src_a};
            mplier <= src_b;
            op_q   <= op;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
`ifdef EARLY_TERM_EN
          if (mplier == '0) begin
            // No set bits remain, so every further step would add nothing
            done  <= 1'b1;
            state <= DONE;
          end else begin
            acc    <= acc_step;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_ONE;
            if (last_run) begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
`else
          acc    <= acc_step;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_ONE;
          if (last_run) begin
            done  <= 1'b1;
            state <= DONE;
          end
`endif
        end
        DONE: begin
          if (op_q) begin
            {hi, lo} <= hilo_mad;
          end else begin
            {hi, lo} <= acc;
          end
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // MFHI/MFLO read port always reflects the committed pair, never the in-flight accumulator
  always_comb begin
    rd_data = '0;
    case (rd_sel)
      2'b01:   rd_data = hi;
      2'b10:   rd_data = lo;
      default: rd_data = '0;
    endcase
  end

  // Hold the pipeline while busy if it wants the unit again or wants to read HI/LO
  always_comb begin
    rd_hit = (rd_sel == 2'b01) || (rd_sel == 2'b10);
    stall  = busy && (start || rd_hit);
  end

endmodule

// File: tb/tb_mul_hilo_seq.sv
// tb/tb_mul_hilo_seq.sv - randomized bench for mul_hilo_seq against an arithmetic HI/LO model
module tb_mul_hilo_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         op;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic [1:0]   rd_sel;
  logic [W-1:0] rd_data;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         stall;
  logic         done;

  int total = 0;
  int bad   = 0;
  logic [2*W-1:0] model_hilo;

  always #5 clk = ~clk;

  mul_hilo_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .rd_sel(rd_sel), .rd_data(rd_data),
    .hi(hi), .lo(lo), .busy(busy), .stall(stall), .done(done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_runs(input logic [W-1:0] b);
`ifdef EARLY_TERM_EN
    int m = -1;
    for (int i = 0; i < W; i++) if (b[i]) m = i;
    return (m + 2 < W) ? m + 2 : W;
`else
    return W;
`endif
  endfunction

  function automatic logic [W-1:0] exp_rd(input logic [1:0] s);
    case (s)
      2'b01:   return model_hilo[2*W-1:W];
      2'b10:   return model_hilo[W-1:0];
      default: return '0;
    endcase
  endfunction

  // Issues one operation in the current (idle) cycle and follows it to the IDLE cycle after DONE.
  task automatic run_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [1:0] rs, input logic harass);
    logic [2*W-1:0] old;
    logic [2*W-1:0] prod;
    int runs, busy_n, done_n, done_at, i;
    start = 1'b1; op = o; src_a = a; src_b = b; rd_sel = rs;
    #1;
    check("idle_stall", 64'(stall), 64'(0));
    check("idle_rd", 64'(rd_data), 64'(exp_rd(rs)));
    runs = exp_runs(b);
    old  = model_hilo;
    prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    model_hilo = o ? model_hilo + prod : prod;
    busy_n = 0; done_n = 0; done_at = 0;
    @(negedge clk);
    i = 1;
    if (harass) begin
      start = 1'b1; op = ~o; src_a = $urandom; src_b = $urandom; rd_sel = 2'b01;
    end else begin
      start = 1'b0; rd_sel = 2'b00;
    end
    forever begin
      #1;
      if (!busy) break;
      busy_n++;
      if (done) begin
        done_n++;
        if (done_at == 0) done_at = i;
      end
      if (harass) begin
        check("busy_stall", 64'(stall), 64'(1));
        check("busy_rd_hi", 64'(rd_data), 64'(old[2*W-1:W]));
      end
      if (i >= 200) break;
      @(negedge clk);
      i++;
    end
    if (harass) begin
      check("post_stall", 64'(stall), 64'(0));
      check("post_rd_hi", 64'(rd_data), 64'(model_hilo[2*W-1:W]));
    end
    start = 1'b0; rd_sel = 2'b00;
    check("busy_cycles", 64'(busy_n), 64'(runs + 1));
    check("done_cycle", 64'(done_at), 64'(runs + 1));
    check("done_count", 64'(done_n), 64'(1));
    check("hi", 64'(hi), 64'(model_hilo[2*W-1:W]));
    check("lo", 64'(lo), 64'(model_hilo[W-1:0]));
  endtask

  initial begin
    int seen_busy, seen_done;
    logic [W-1:0] ra, rb;
    rst_n = 1'b0; start = 1'b0; op = 1'b0; src_a = '0; src_b = '0; rd_sel = 2'b01;
    model_hilo = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_stall", 64'(stall), 64'(0));
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    check("rst_rd", 64'(rd_data), 64'(0));
    rst_n = 1'b1; rd_sel = 2'b00;
    @(negedge clk);

    run_op(1'b0, 32'd3, 32'd5, 2'b00, 1'b0);
    check("t1_lo", 64'(lo), 64'h0000000F);
    run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, 1'b0);
    check("t2_hi", 64'(hi), 64'hFFFFFFFE);
    check("t2_lo", 64'(lo), 64'h00000001);
    run_op(1'b1, 32'd1, 32'hFFFFFFFF, 2'b01, 1'b0);
    check("t3_hi", 64'(hi), 64'hFFFFFFFF);
    check("t3_lo", 64'(lo), 64'h00000000);
    run_op(1'b1, 32'd0, 32'd7, 2'b01, 1'b0);
    check("t3b_hi", 64'(hi), 64'hFFFFFFFF);
    check("t3b_lo", 64'(lo), 64'h00000000);
    run_op(1'b0, $urandom, $urandom, 2'b01, 1'b1);
    ra = $urandom;
    run_op(1'b0, ra, 32'd5, 2'b10, 1'b0);
    run_op(1'b0, $urandom, 32'd0, 2'b00, 1'b0);

    for (int n = 0; n < 24; n++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      run_op(1'(($urandom >> 3) & 1), ra, rb, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 4) == 0));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    @(negedge clk);
    start = 1'b1; op = 1'b0; src_a = 32'h1234_5678; src_b = 32'h8000_0001; rd_sel = 2'b00;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0; rd_sel = 2'b01;
    #1;
    model_hilo = '0;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_stall", 64'(stall), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_hi", 64'(hi), 64'(0));
    check("abort_lo", 64'(lo), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    seen_busy = 0; seen_done = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (busy) seen_busy++;
      if (done) seen_done++;
    end
    check("abort_no_busy", 64'(seen_busy), 64'(0));
    check("abort_no_done", 64'(seen_done), 64'(0));
    check("abort_hi_after", 64'(hi), 64'(0));
    check("abort_lo_after", 64'(lo), 64'(0));

    run_op(1'b1, 32'd9, 32'd11, 2'b01, 1'b0);
    check("post_abort_lo", 64'(lo), 64'd99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
